// File: rtl/hack_pkg.sv
// Shared widths for the Hack memory tiers (RAM8 and the tiers built from it).
package hack_pkg;

    localparam int unsigned WORD_W      = 16;
    localparam int unsigned RAM8_DEPTH  = 8;
    localparam int unsigned RAM8_ADDR_W = 3;

endpackage

// File: rtl/ram8_rw_register.sv
// WIDTH-bit load-enabled storage register, asynchronously cleared to zero.
module ram8_rw_register
    import hack_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ram8_rw.sv
// Eight-word register memory: one write port, one registered read port.
// Build with RAM8_RW_BYPASS_EN for write-first forwarding on same-address collisions.
module ram8_rw
    import hack_pkg::*;
#(
    parameter int unsigned WIDTH  = WORD_W,
    parameter int unsigned DEPTH  = RAM8_DEPTH,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  in,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  out,
    output logic              out_valid
);

    logic [WIDTH-1:0] words [DEPTH];
    logic [DEPTH-1:0] word_load;
    logic [WIDTH-1:0] rd_word;

    // One-hot demux of load onto the addressed word
    always_comb begin
        word_load = '0;
        if (load) begin
            word_load[wr_addr] = 1'b1;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        ram8_rw_register #(
            .WIDTH (WIDTH)
        ) u_word (
            .clk  (clk),
            .rst  (rst),
            .load (word_load[i]),
            .d    (in),
            .q    (words[i])
        );
    end

    // Read mux; storage still holds old data at the edge, so default is read-before-write
    always_comb begin
        rd_word = words[rd_addr];
`ifdef RAM8_RW_BYPASS_EN
        if (load && (wr_addr == rd_addr)) begin
            rd_word = in;
        end
`endif
    end

    ram8_rw_register #(
        .WIDTH (WIDTH)
    ) u_out (
        .clk  (clk),
        .rst  (rst),
        .load (rd_en),
        .d    (rd_word),
        .q    (out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= rd_en;
        end
    end

endmodule

// File: tb/tb_ram8_rw.sv
// Directed scoreboard bench for ram8_rw (honours RAM8_RW_BYPASS_EN).
module tb_ram8_rw;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [2:0]  wr_addr;
    logic [15:0] din;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [15:0] out;
    logic        out_valid;

    logic [15:0] model [8];
    logic [15:0] last_out;
    logic [15:0] sb [$];
    int          n_cmp = 0;
    int          n_err = 0;

    ram8_rw dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .wr_addr   (wr_addr),
        .in        (din),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_read(input logic ld, input logic [2:0] wa,
                                             input logic [15:0] d, input logic [2:0] ra);
`ifdef RAM8_RW_BYPASS_EN
        if (ld && wa == ra) return d;
`endif
        return model[ra];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        last_out = 16'h0000;
        sb.delete();
    endtask

    // One clock: drive ports, push expectation, check outputs 1 ns after the edge
    task automatic cycle(input string tag, input logic ld, input logic [2:0] wa,
                         input logic [15:0] d, input logic re, input logic [2:0] ra);
        load = ld; wr_addr = wa; din = d; rd_en = re; rd_addr = ra;
        if (re) sb.push_back(exp_read(ld, wa, d, ra));
        @(posedge clk);
        #1;
        if (ld) model[wa] = d;
        chk({tag, "_valid"}, {15'b0, out_valid}, {15'b0, re});
        if (re) begin
            if (sb.size() == 0) begin
                chk({tag, "_sb_empty"}, 16'h0001, 16'h0000);
            end else begin
                last_out = sb.pop_front();
                chk({tag, "_out"}, out, last_out);
            end
        end else begin
            chk({tag, "_hold"}, out, last_out);
        end
        load = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; wr_addr = '0; din = '0; rd_en = 1'b0; rd_addr = '0;
        clear_model();
        #2;
        chk("reset_out", out, 16'h0000);
        chk("reset_valid", {15'b0, out_valid}, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: dirty memory, reset mid-run, every word reads back zero
        for (int i = 0; i < 8; i++) cycle("pre_wr", 1'b1, 3'(i), 16'h5A00 + 16'(i), 1'b0, 3'd0);
        cycle("pre_rd", 1'b0, 3'd0, 16'h0, 1'b1, 3'd4);
        #2 rst = 1'b1;
        #1;
        clear_model();
        chk("rst1_out", out, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle("rst_rd", 1'b0, 3'd0, 16'h0, 1'b1, 3'(i));
            cycle("rst_gap", 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
        end

        // 2: write sweep, back-to-back read-back in reverse
        for (int i = 0; i < 8; i++) cycle("sw_wr", 1'b1, 3'(i), 16'hA5A0 + 16'(i), 1'b0, 3'd0);
        for (int i = 7; i >= 0; i--) cycle("sw_rd", 1'b0, 3'd0, 16'h0, 1'b1, 3'(i));
        chk("sweep_last", out, 16'hA5A0);
        cycle("sw_end", 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);

        // 3: isolation around a single write
        cycle("iso_wr", 1'b1, 3'd3, 16'hFFFF, 1'b0, 3'd0);
        cycle("iso_rd2", 1'b0, 3'd0, 16'h0, 1'b1, 3'd2);
        chk("iso_2", out, 16'hA5A2);
        cycle("iso_rd4", 1'b0, 3'd0, 16'h0, 1'b1, 3'd4);
        chk("iso_4", out, 16'hA5A4);
        cycle("iso_rd3", 1'b0, 3'd0, 16'h0, 1'b1, 3'd3);
        chk("iso_3", out, 16'hFFFF);

        // 4: same-address collision, plus a different-address pair on one edge
        cycle("col_set", 1'b1, 3'd5, 16'h1111, 1'b0, 3'd0);
        cycle("col", 1'b1, 3'd5, 16'h2222, 1'b1, 3'd5);
`ifdef RAM8_RW_BYPASS_EN
        chk("col_fwd", out, 16'h2222);
`else
        chk("col_rbw", out, 16'h1111);
`endif
        cycle("col_after", 1'b0, 3'd0, 16'h0, 1'b1, 3'd5);
        chk("col_new", out, 16'h2222);
        cycle("diff", 1'b1, 3'd1, 16'hBEEF, 1'b1, 3'd7);
        cycle("diff_rd1", 1'b0, 3'd0, 16'h0, 1'b1, 3'd1);

        // 5: out holds after a read while rd_en is low
        cycle("hold_wr", 1'b1, 3'd6, 16'h1234, 1'b0, 3'd0);
        cycle("hold_rd", 1'b0, 3'd0, 16'h0, 1'b1, 3'd6);
        for (int i = 0; i < 4; i++) cycle("hold", 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
        chk("hold_val", out, 16'h1234);

        // 6: async reset between edges with a read pending
        cycle("ar_rd", 1'b0, 3'd0, 16'h0, 1'b1, 3'd6);
        rd_en = 1'b1; rd_addr = 3'd1;
        #2 rst = 1'b1;
        #1;
        chk("ar_out", out, 16'h0000);
        chk("ar_valid", {15'b0, out_valid}, 16'h0000);
        clear_model();
        @(posedge clk); #1;
        chk("ar_hold_valid", {15'b0, out_valid}, 16'h0000);
        rd_en = 1'b0;
        rst = 1'b0;
        cycle("ar_rd0", 1'b0, 3'd0, 16'h0, 1'b1, 3'd0);
        chk("ar_zero", out, 16'h0000);
        cycle("ar_rd1", 1'b0, 3'd0, 16'h0, 1'b1, 3'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
